hsv_core_writeback: RTL and testbench
=====================================

HSV_CORE_WRITEBACK -- requirements
Module: hsv_core_writeback

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data width of a register write.
REQ-002 The block SHALL have parameter NSRC, default 4, meaning the number of result sources: 0=alu, 1=branch, 2=ctrl_status, 3=mem.
REQ-003 The block SHALL have port clk_core, input, 1 bit, the core clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_core_n, input, 1 bit, the core reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port flush_req, input, 1 bit, the pipeline flush request.
REQ-006 The block SHALL have port flush_ack, output, 1 bit, the flush acknowledge.
REQ-007 The block SHALL have port src_valid_i, input, NSRC bits, the per-source result-valid flags.
REQ-008 The block SHALL have port src_ready_o, output, NSRC bits, the per-source accept flags.
REQ-009 The block SHALL have port src_rd_addr, input, NSRC*5 bits, the destination register for each source; slice i is [5i+4:5i].
REQ-010 The block SHALL have port src_rd_data, input, NSRC*XLEN bits, the result data for each source; slice i is [XLEN*i+XLEN-1:XLEN*i].
REQ-011 The block SHALL have port src_rd_en, input, NSRC bits, the per-source "result writes rd" flags.
REQ-012 The block SHALL have port wr_addr, output, 5 bits, the register-file write address.
REQ-013 The block SHALL have port wr_data, output, XLEN bits, the register-file write data.
REQ-014 The block SHALL have port wr_en, output, 1 bit, the register-file write enable.
REQ-015 The block SHALL have port retired_count, output, 64 bits, the count of accepted results.

Function
REQ-016 The block SHALL perform at most one handshake per cycle; a handshake on source i is src_valid_i[i] & src_ready_o[i] in the same cycle.
REQ-017 The block SHALL keep src_ready_o at most one-hot, with src_ready_o[i] = grant[i] & ~flush_req, where grant is combinational.
REQ-018 The grant SHALL be round-robin: it goes to the first valid source found by scanning from rr_ptr upward, modulo NSRC.
REQ-019 When no source is valid, grant SHALL be all-zero.
REQ-020 On a handshake with source g, rr_ptr SHALL become (g+1) mod NSRC; with no handshake, rr_ptr SHALL hold its value.
REQ-021 The write latency SHALL be 1 cycle: in the cycle after a handshake on source g, wr_addr = src_rd_addr[g] and wr_data = src_rd_data[g], both registered.
REQ-022 In that cycle, wr_en SHALL equal src_rd_en[g] & (src_rd_addr[g] != 0), so writes to x0 are suppressed.
REQ-023 In a cycle after no handshake, wr_en SHALL be 0 and wr_addr and wr_data SHALL hold their previous values.
REQ-024 retired_count SHALL increment by 1 on every handshake, including rd_en=0 and x0 results.
REQ-025 retired_count SHALL wrap from 2^64-1 to 0 and SHALL NOT saturate.
REQ-026 While flush_req=1: src_ready_o SHALL be all-zero and no handshake SHALL occur.
REQ-027 While flush_req=1: wr_en SHALL be 0 in the following cycle.
REQ-028 While flush_req=1: rr_ptr SHALL be set to 0.
REQ-029 A flush SHALL leave retired_count unchanged.
REQ-030 flush_ack SHALL equal flush_req delayed by one register stage.
REQ-031 A write already registered when flush_req rises SHALL still be presented on the write port for its cycle, because it belongs to an instruction already committed.
REQ-032 Sources not granted SHALL see src_ready_o=0; the block relies on the source holding valid and data stable until accepted.
REQ-033 If all NSRC sources are valid every cycle, each source SHALL be accepted exactly once every NSRC cycles, so no source starves.

Reset
REQ-034 While rst_core_n=0, the block SHALL drive wr_en=0, wr_addr=0, wr_data=0, retired_count=0 and flush_ack=0, and SHALL set rr_ptr=0.
REQ-035 While rst_core_n=0, src_ready_o SHALL be all-zero regardless of src_valid_i.
REQ-036 Reset asserted mid-operation SHALL discard any registered write, with no wr_en pulse after reset release.
REQ-037 After release, the first grant SHALL scan from source 0.

Verification
REQ-038 Bench scenario: single alu result, rd=5, data=0xDEADBEEF, rd_en=1 -> src_ready_o=0001 in the same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; retired_count=1.
REQ-039 Bench scenario: all four sources valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 writes; retired_count=8.
REQ-040 Bench scenario: mem result with rd=0 and rd_en=1, then a branch result with rd_en=0 -> wr_en=0 both cycles; retired_count increments by 2.
REQ-041 Bench scenario: flush_req held for 2 cycles with all sources valid -> src_ready_o=0000 both cycles; flush_ack high for 2 cycles, lagging by one; after release, the first grant is source 0.
REQ-042 Bench scenario: retired_count preset to 2^64-1 by forcing, then one handshake -> retired_count=0.
REQ-043 Bench scenario: reset asserted in the cycle after a handshake -> wr_en=0 immediately and on release; rr_ptr=0.

Source files
------------

// File: rtl/hsv_core_writeback.sv
// Writeback stage: round-robin arbitration over result sources, one register-file
// write per cycle with one cycle of latency, and a retired-instruction counter.
module hsv_core_writeback #(
  parameter int XLEN = 32,
  parameter int NSRC = 4
) (
  input  logic                 clk_core,
  input  logic                 rst_core_n,
  input  logic                 flush_req,
  output logic                 flush_ack,
  input  logic [NSRC-1:0]      src_valid_i,
  output logic [NSRC-1:0]      src_ready_o,
  input  logic [NSRC*5-1:0]    src_rd_addr,
  input  logic [NSRC*XLEN-1:0] src_rd_data,
  input  logic [NSRC-1:0]      src_rd_en,
  output logic [4:0]           wr_addr,
  output logic [XLEN-1:0]      wr_data,
  output logic                 wr_en,
  output logic [63:0]          retired_count
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [NSRC-1:0] grant;
  logic [PW-1:0]   gidx;
  logic            found;
  int              idx;
  logic            handshake;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;
  logic            sel_en;
  logic [PW-1:0]   next_ptr;

  // First valid source at or above rr_ptr, wrapping modulo NSRC.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NSRC; k++) begin
      idx = (int'(rr_ptr) + k) % NSRC;
      if (!found && src_valid_i[idx]) begin
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
        found      = 1'b1;
      end
    end
  end

  assign src_ready_o = (rst_core_n && !flush_req) ? grant : '0;
  assign handshake   = |(src_valid_i & src_ready_o);

  assign sel_addr = src_rd_addr[int'(gidx)*5 +: 5];
  assign sel_data = src_rd_data[int'(gidx)*XLEN +: XLEN];
  assign sel_en   = src_rd_en[gidx];
  assign next_ptr = (int'(gidx) == NSRC - 1) ? '0 : gidx + 1'b1;

  // Address and data hold between writes; only the enable pulses.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      rr_ptr        <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      retired_count <= '0;
      flush_ack     <= 1'b0;
    end else begin
      flush_ack <= flush_req;
      wr_en     <= handshake && sel_en && (sel_addr != 5'd0);
      if (handshake) begin
        wr_addr       <= sel_addr;
        wr_data       <= sel_data;
        retired_count <= retired_count + 64'd1;
      end
      if (flush_req)
        rr_ptr <= '0;
      else if (handshake)
        rr_ptr <= next_ptr;
    end
  end

endmodule

// File: tb/tb_hsv_core_writeback.sv
// Directed testbench for hsv_core_writeback: arbitration order, write latency,
// x0 suppression, flush, counter wrap and mid-operation reset.
module tb_hsv_core_writeback;

  logic         clk_core;
  logic         rst_core_n;
  logic         flush_req;
  logic         flush_ack;
  logic [3:0]   src_valid_i;
  logic [3:0]   src_ready_o;
  logic [19:0]  src_rd_addr;
  logic [127:0] src_rd_data;
  logic [3:0]   src_rd_en;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         wr_en;
  logic [63:0]  retired_count;

  int total;
  int passed;

  hsv_core_writeback #(.XLEN(32), .NSRC(4)) dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n),
    .flush_req(flush_req), .flush_ack(flush_ack),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data), .src_rd_en(src_rd_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .retired_count(retired_count)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  task automatic set_src(input int i, input logic v, input logic [4:0] a,
                         input logic [31:0] d, input logic e);
    src_valid_i[i]        = v;
    src_rd_addr[i*5 +: 5] = a;
    src_rd_data[i*32 +: 32] = d;
    src_rd_en[i]          = e;
  endtask

  task automatic clear_srcs();
    src_valid_i = '0;
    src_rd_addr = '0;
    src_rd_data = '0;
    src_rd_en   = '0;
  endtask

  // Drive reset across one rising edge and release it on a falling edge.
  task automatic do_reset();
    @(negedge clk_core);
    rst_core_n = 1'b0;
    flush_req  = 1'b0;
    clear_srcs();
    @(posedge clk_core);
    @(negedge clk_core);
    rst_core_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_core_n = 1'b0;
    flush_req  = 1'b0;
    clear_srcs();
    src_valid_i = 4'b1111;
    @(posedge clk_core);
    #1;
    total++; if (src_ready_o !== 4'b0000) $display("[TB] FAIL reset_ready: got %b expected 0000", src_ready_o); else passed++;
    total++; if (wr_en !== 1'b0) $display("[TB] FAIL reset_wr_en: got %b expected 0", wr_en); else passed++;
    total++; if (wr_addr !== 5'd0) $display("[TB] FAIL reset_wr_addr: got %0d expected 0", wr_addr); else passed++;
    total++; if (wr_data !== 32'd0) $display("[TB] FAIL reset_wr_data: got %h expected 0", wr_data); else passed++;
    total++; if (retired_count !== 64'd0) $display("[TB] FAIL reset_count: got %0d expected 0", retired_count); else passed++;
    total++; if (flush_ack !== 1'b0) $display("[TB] FAIL reset_flush_ack: got %b expected 0", flush_ack); else passed++;
    @(negedge clk_core);
    clear_srcs();
    rst_core_n = 1'b1;
  endtask

  task automatic test_single_alu();
    do_reset();
    set_src(0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    #1;
    total++; if (src_ready_o !== 4'b0001) $display("[TB] FAIL alu_ready: got %b expected 0001", src_ready_o); else passed++;
    @(posedge clk_core);
    #1;
    clear_srcs();
    total++; if (wr_en !== 1'b1) $display("[TB] FAIL alu_wr_en: got %b expected 1", wr_en); else passed++;
    total++; if (wr_addr !== 5'd5) $display("[TB] FAIL alu_wr_addr: got %0d expected 5", wr_addr); else passed++;
    total++; if (wr_data !== 32'hDEADBEEF) $display("[TB] FAIL alu_wr_data: got %h expected deadbeef", wr_data); else passed++;
    total++; if (retired_count !== 64'd1) $display("[TB] FAIL alu_count: got %0d expected 1", retired_count); else passed++;
    @(posedge clk_core);
    #1;
    total++; if (wr_en !== 1'b0) $display("[TB] FAIL alu_idle_wr_en: got %b expected 0", wr_en); else passed++;
    total++; if (wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF)
      $display("[TB] FAIL alu_hold: got addr %0d data %h expected 5 deadbeef", wr_addr, wr_data); else passed++;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b1);
    for (int c = 0; c < 8; c++) begin
      #1;
      total++; if (src_ready_o !== 4'(1 << (c % 4)))
        $display("[TB] FAIL rr_grant_%0d: got %b expected %b", c, src_ready_o, 4'(1 << (c % 4))); else passed++;
      @(posedge clk_core);
      #1;
      total++; if (wr_en !== 1'b1 || wr_addr !== 5'((c % 4) + 1) || wr_data !== 32'h100 + 32'(c % 4))
        $display("[TB] FAIL rr_write_%0d: got en %b addr %0d data %h expected 1 %0d %h",
                 c, wr_en, wr_addr, wr_data, (c % 4) + 1, 32'h100 + 32'(c % 4)); else passed++;
      @(negedge clk_core);
    end
    clear_srcs();
    total++; if (retired_count !== 64'd8) $display("[TB] FAIL rr_count: got %0d expected 8", retired_count); else passed++;
  endtask

  task automatic test_x0_and_noen();
    do_reset();
    set_src(3, 1'b1, 5'd0, 32'h1234, 1'b1);
    #1;
    total++; if (src_ready_o !== 4'b1000) $display("[TB] FAIL x0_ready: got %b expected 1000", src_ready_o); else passed++;
    @(posedge clk_core);
    #1;
    total++; if (wr_en !== 1'b0) $display("[TB] FAIL x0_wr_en: got %b expected 0", wr_en); else passed++;
    @(negedge clk_core);
    clear_srcs();
    set_src(1, 1'b1, 5'd7, 32'h5678, 1'b0);
    #1;
    total++; if (src_ready_o !== 4'b0010) $display("[TB] FAIL noen_ready: got %b expected 0010", src_ready_o); else passed++;
    @(posedge clk_core);
    #1;
    clear_srcs();
    total++; if (wr_en !== 1'b0) $display("[TB] FAIL noen_wr_en: got %b expected 0", wr_en); else passed++;
    total++; if (retired_count !== 64'd2) $display("[TB] FAIL x0_count: got %0d expected 2", retired_count); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    set_src(0, 1'b1, 5'd9, 32'hCAFE0000, 1'b1);
    @(posedge clk_core);
    @(negedge clk_core);
    for (int i = 0; i < 4; i++) set_src(i, 1'b1, 5'd9 + 5'(i), 32'hCAFE0000 + 32'(i), 1'b1);
    flush_req = 1'b1;
    #1;
    total++; if (wr_en !== 1'b1 || wr_addr !== 5'd9) $display("[TB] FAIL flush_committed_write: got en %b addr %0d expected 1 9", wr_en, wr_addr); else passed++;
    total++; if (flush_ack !== 1'b0) $display("[TB] FAIL flush_ack_lag: got %b expected 0", flush_ack); else passed++;
    for (int c = 0; c < 2; c++) begin
      total++; if (src_ready_o !== 4'b0000) $display("[TB] FAIL flush_ready_%0d: got %b expected 0000", c, src_ready_o); else passed++;
      @(posedge clk_core);
      #1;
      total++; if (flush_ack !== 1'b1) $display("[TB] FAIL flush_ack_%0d: got %b expected 1", c, flush_ack); else passed++;
      total++; if (wr_en !== 1'b0) $display("[TB] FAIL flush_wr_en_%0d: got %b expected 0", c, wr_en); else passed++;
      @(negedge clk_core);
      if (c == 1) flush_req = 1'b0;
      #1;
    end
    total++; if (src_ready_o !== 4'b0001) $display("[TB] FAIL flush_first_grant: got %b expected 0001", src_ready_o); else passed++;
    @(posedge clk_core);
    #1;
    clear_srcs();
    total++; if (flush_ack !== 1'b0) $display("[TB] FAIL flush_ack_drop: got %b expected 0", flush_ack); else passed++;
    total++; if (wr_en !== 1'b1 || wr_addr !== 5'd9) $display("[TB] FAIL flush_resume_write: got en %b addr %0d expected 1 9", wr_en, wr_addr); else passed++;
    total++; if (retired_count !== 64'd2) $display("[TB] FAIL flush_count: got %0d expected 2", retired_count); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.retired_count = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retired_count;
    set_src(2, 1'b1, 5'd3, 32'h0BAD, 1'b1);
    @(posedge clk_core);
    #1;
    total++; if (retired_count !== 64'd0) $display("[TB] FAIL wrap_count: got %h expected 0", retired_count); else passed++;
    @(posedge clk_core);
    #1;
    clear_srcs();
    total++; if (retired_count !== 64'd1) $display("[TB] FAIL wrap_next: got %h expected 1", retired_count); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_src(0, 1'b1, 5'd5, 32'h600D, 1'b1);
    @(posedge clk_core);
    #1;
    clear_srcs();
    #1;
    rst_core_n = 1'b0;
    #1;
    total++; if (wr_en !== 1'b0 || wr_addr !== 5'd0) $display("[TB] FAIL midrst_wr: got en %b addr %0d expected 0 0", wr_en, wr_addr); else passed++;
    total++; if (retired_count !== 64'd0) $display("[TB] FAIL midrst_count: got %0d expected 0", retired_count); else passed++;
    @(negedge clk_core);
    rst_core_n = 1'b1;
    @(posedge clk_core);
    #1;
    total++; if (wr_en !== 1'b0) $display("[TB] FAIL midrst_release_wr_en: got %b expected 0", wr_en); else passed++;
    @(negedge clk_core);
    set_src(0, 1'b1, 5'd1, 32'h1, 1'b1);
    set_src(2, 1'b1, 5'd2, 32'h2, 1'b1);
    #1;
    total++; if (src_ready_o !== 4'b0001) $display("[TB] FAIL midrst_ptr: got %b expected 0001", src_ready_o); else passed++;
    @(posedge clk_core);
    #1;
    clear_srcs();
  endtask

  initial begin
    total  = 0;
    passed = 0;
    $display("[TB] starting hsv_core_writeback bench");
    test_reset();
    test_single_alu();
    test_round_robin();
    test_x0_and_noen();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
